conv_encoder_pipe: RTL

Parametrised rate-1/N convolutional encoder. It is the stimulus source for the Fano decoder benches and is also intended for loopback builds.
- Generalises the fixed 1/2, K=36 encoder: configurable constraint length, output count, polynomials and systematic mode.
- Valid/ready handshake with full backpressure through a registered parity tree.
- Optional zero-tail frame termination.

---
 rtl/conv_enc_pkg.sv | 10 +
 rtl/conv_encoder_pipe_xor_tree.sv | 28 ++
 rtl/conv_encoder_pipe.sv | 88 ++++++++
 3 files changed

// File: rtl/conv_enc_pkg.sv
// conv_enc_pkg: shared constants, state type and reference parity for the convolutional encoder
package conv_enc_pkg;
  localparam int K_MAX = 64;
  localparam int N_OUT_MAX = 4;
  localparam logic [35:0] DEFAULT_POLY_K36 = 36'hD354E3267;
  typedef enum logic {RUN, TAIL} enc_state_t;
  function automatic logic parity_ref(input logic [K_MAX-1:0] w, input logic [K_MAX-1:0] mask);
    return ^(w & mask);
  endfunction
endpackage

// File: rtl/conv_encoder_pipe_xor_tree.sv
// xor_tree_pipe: registered binary XOR reduction of a W-bit word, one tree level per pipeline stage
module xor_tree_pipe #(
  parameter int W = 36,
  parameter int LVL = $clog2(W)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [W-1:0] data,
  output logic         parity
);
  localparam int P = 2 ** LVL;
  logic [P-1:0] leaf;
  logic [P-1:1] node, node_nx;
  logic [2*P-1:1] t;
  assign leaf = P'(data);
  assign t = {leaf, node};
  assign parity = node[1];
  // heap-ordered tree: node i folds its two children 2i and 2i+1, leaves sit above the nodes
  always_comb begin
    node_nx = '0;
    for (int i = 1; i < P; i++) node_nx[i] = t[2*i] ^ t[2*i+1];
  end
  // every level advances together so a stall freezes the whole tree
  always_ff @(posedge clk)
    if (!reset_n) node <= '0;
    else if (en) node <= node_nx;
endmodule

// File: rtl/conv_encoder_pipe.sv
// conv_encoder_pipe: rate-1/N convolutional encoder with stallable registered parity trees;
// define CONV_ENC_TAIL_EN for zero-tail frame termination (RUN/TAIL state machine)
module conv_encoder_pipe import conv_enc_pkg::*; #(
  parameter int K = 36,
  parameter int N_OUT = 2,
  parameter int SYSTEMATIC = 1,
  parameter logic [N_OUT*K-1:0] POLY = (N_OUT*K)'({36'h0, DEFAULT_POLY_K36}),
  parameter int LVL = $clog2(K)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_vld,
  output logic             o_rdy,
  input  logic             i_sym,
  input  logic             i_last,
  output logic             o_vld,
  input  logic             i_rdy,
  output logic [N_OUT-1:0] o_word,
  output logic             o_last
);
  logic en, acc, ins, bit_in, last_in;
  logic [K-1:0] w;
  logic [LVL:0] vd, ld, sd;
  assign en = !o_vld | i_rdy;
  assign acc = i_vld & o_rdy;
`ifdef CONV_ENC_TAIL_EN
  enc_state_t state, state_nx;
  logic [LVL-1:0] tail_cnt, tail_nx;
  logic tail_end;
  assign tail_end = tail_cnt == LVL'(K - 2);
  // state and tail counter move only on enabled cycles
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= RUN;
      tail_cnt <= '0;
    end else if (en) begin
      state <= state_nx;
      tail_cnt <= tail_nx;
    end
  // enter TAIL after the last info bit, leave once K-1 zeros have been pushed
  always_comb begin
    state_nx = state == RUN ? (acc & i_last ? TAIL : RUN) : (tail_end ? RUN : TAIL);
    tail_nx = state == TAIL ? tail_cnt + LVL'(1) : '0;
  end
  // TAIL blocks the input and injects valid zero bits, the final one tagged last
  always_comb begin
    o_rdy = reset_n & en & (state == RUN);
    ins = state == TAIL ? en : i_vld & reset_n & en;
    bit_in = state == RUN & i_sym;
    last_in = state == TAIL & tail_end;
  end
`else
  assign o_rdy = reset_n & en;
  assign ins = acc;
  assign bit_in = i_sym;
  assign last_in = i_last;
`endif
  // newest bit enters at w[0]; bubbles leave the window untouched
  always_ff @(posedge clk)
    if (!reset_n) w <= '0;
    else if (en & ins) w <= {w[K-2:0], bit_in};
  // valid, last and systematic bits ride alongside the window and tree levels
  always_ff @(posedge clk)
    if (!reset_n) begin
      vd <= '0;
      ld <= '0;
      sd <= '0;
    end else if (en) begin
      vd <= {vd[LVL-1:0], ins};
      ld <= {ld[LVL-1:0], ins & last_in};
      sd <= {sd[LVL-1:0], ins & bit_in};
    end
  assign o_vld = vd[LVL];
  assign o_last = ld[LVL];
  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    if (SYSTEMATIC != 0 && j == N_OUT - 1) begin : g_sys
      assign o_word[j] = sd[LVL];
    end else begin : g_par
      xor_tree_pipe #(.W(K), .LVL(LVL)) u_tree (
        .clk(clk),
        .reset_n(reset_n),
        .en(en),
        .data(w & POLY[j*K +: K]),
        .parity(o_word[j])
      );
    end
  end
endmodule
